// File: rtl/dual_issue_unit.sv
// Decode-side dual-issue stage: issues a fetched pair together, or splits a
// hazardous pair over two cycles while holding fetch for one cycle.
module dual_issue_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            FlushD,
  input  logic [XLEN-1:0] InstrD1,
  input  logic [XLEN-1:0] InstrD2,
  input  logic [XLEN-1:0] PCD,
  output logic            StallF,
  output logic [XLEN-1:0] InstrE1,
  output logic [XLEN-1:0] InstrE2,
  output logic            ValidE1,
  output logic            ValidE2,
  output logic [XLEN-1:0] PCE1,
  output logic [XLEN-1:0] PCE2
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic {PAIR, SPLIT} state_t;
  state_t state_q;

  function automatic logic has_rd(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  endfunction

  function automatic logic has_rs1(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JALR};
  endfunction

  function automatic logic has_rs2(input logic [6:0] op);
    return op inside {OP_R, OP_STORE, OP_BR};
  endfunction

  logic [6:0]      op1, op2;
  logic [4:0]      rd1, rd2, rs1_2, rs2_2;
  logic            v1, v2, wr1, wr2, raw, waw, mem, ctrl, conflict;
  logic [XLEN-1:0] pcd4;

  always_comb begin
    op1   = InstrD1[6:0];
    op2   = InstrD2[6:0];
    rd1   = InstrD1[11:7];
    rd2   = InstrD2[11:7];
    rs1_2 = InstrD2[19:15];
    rs2_2 = InstrD2[24:20];
    v1    = |InstrD1;
    v2    = |InstrD2;
    wr1   = has_rd(op1) && (rd1 != 5'd0);
    wr2   = has_rd(op2) && (rd2 != 5'd0);
    raw   = wr1 && ((has_rs1(op2) && rs1_2 == rd1) || (has_rs2(op2) && rs2_2 == rd1));
    waw   = wr1 && wr2 && (rd1 == rd2);
    mem   = (op1 inside {OP_LOAD, OP_STORE}) && (op2 inside {OP_LOAD, OP_STORE});
    ctrl  = op1 inside {OP_BR, OP_JAL, OP_JALR};
    conflict = v1 && v2 && (raw || waw || mem || ctrl);
    pcd4  = PCD + XLEN'(4);
    // Only a fresh pair in PAIR can stall; SPLIT drains the held I2 without stalling.
    StallF = !rst && !FlushD && (state_q == PAIR) && conflict;
  end

  always_ff @(posedge clk) begin
    if (rst || FlushD) begin
      state_q <= PAIR;
      ValidE1 <= 1'b0;
      ValidE2 <= 1'b0;
      InstrE1 <= '0;
      InstrE2 <= '0;
      PCE1    <= '0;
      PCE2    <= '0;
    end else begin
      case (state_q)
        PAIR: begin
          ValidE1 <= v1;
          InstrE1 <= v1 ? InstrD1 : '0;
          PCE1    <= v1 ? PCD : '0;
          if (conflict) begin
            state_q <= SPLIT;
            ValidE2 <= 1'b0;
            InstrE2 <= '0;
            PCE2    <= '0;
          end else begin
            state_q <= PAIR;
            ValidE2 <= v2;
            InstrE2 <= v2 ? InstrD2 : '0;
            PCE2    <= v2 ? pcd4 : '0;
          end
        end
        default: begin
          state_q <= PAIR;
          ValidE1 <= v2;
          InstrE1 <= v2 ? InstrD2 : '0;
          PCE1    <= v2 ? pcd4 : '0;
          ValidE2 <= 1'b0;
          InstrE2 <= '0;
          PCE2    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dual_issue_unit.sv
// Directed bench for dual_issue_unit: each task drives a scenario and checks
// StallF and the packed E-stage outputs against hand-computed values.
module tb_dual_issue_unit;

  logic        clk = 1'b0;
  logic        rst, FlushD;
  logic [31:0] InstrD1, InstrD2, PCD;
  logic        StallF, ValidE1, ValidE2;
  logic [31:0] InstrE1, InstrE2, PCE1, PCE2;
  logic [129:0] obs;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] ADDI1 = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] ADDI2 = 32'h00700113; // addi x2,x0,7
  localparam logic [31:0] ADD3  = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] ADD30 = 32'h000001B3; // add x3,x0,x0
  localparam logic [31:0] LW1   = 32'h00012083;
  localparam logic [31:0] LW3   = 32'h00412183;
  localparam logic [31:0] JAL0  = 32'h0000006F;
  localparam logic [31:0] LUI1  = 32'h000010B7; // lui x1,1

  dual_issue_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .FlushD(FlushD),
    .InstrD1(InstrD1), .InstrD2(InstrD2), .PCD(PCD),
    .StallF(StallF),
    .InstrE1(InstrE1), .InstrE2(InstrE2),
    .ValidE1(ValidE1), .ValidE2(ValidE2),
    .PCE1(PCE1), .PCE2(PCE2)
  );

  always #5 clk = ~clk;
  assign obs = {ValidE1, ValidE2, InstrE1, InstrE2, PCE1, PCE2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i1, input logic [31:0] i2,
                       input logic [31:0] pc, input logic fl);
    InstrD1 = i1; InstrD2 = i2; PCD = pc; FlushD = fl;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive($urandom, $urandom, $urandom, 1'b0);
      tests++;
      if (StallF !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", StallF); end
      tick();
    end
    tests++;
    if (obs !== '0) begin fails++; $display("FAIL reset_outputs got=%h exp=0", obs); end
    rst = 1'b0;
    drive(ADDI1, ADDI2, 32'h100, 1'b0);
    tick();
    tests++;
    if (obs !== {2'b11, ADDI1, ADDI2, 32'h100, 32'h104}) begin
      fails++; $display("FAIL reset_release got=%h", obs);
    end
  endtask

  task automatic test_independent();
    drive(ADDI1, ADDI2, 32'h10, 1'b0);
    tests++;
    if (StallF !== 1'b0) begin fails++; $display("FAIL indep_stall got=%b exp=0", StallF); end
    tick();
    tests++;
    if (obs !== {2'b11, ADDI1, ADDI2, 32'h10, 32'h14}) begin
      fails++; $display("FAIL indep_issue got=%h", obs);
    end
    tests++;
    if (StallF !== 1'b0) begin fails++; $display("FAIL indep_stall2 got=%b exp=0", StallF); end
  endtask

  task automatic test_raw_split();
    drive(ADDI1, ADD3, 32'h20, 1'b0);
    tests++;
    if (StallF !== 1'b1) begin fails++; $display("FAIL raw_stall got=%b exp=1", StallF); end
    tick();
    tests++;
    if (obs !== {2'b10, ADDI1, 32'h0, 32'h20, 32'h0}) begin
      fails++; $display("FAIL raw_first got=%h", obs);
    end
    tests++;
    if (StallF !== 1'b0) begin fails++; $display("FAIL raw_split_stall got=%b exp=0", StallF); end
    tick();
    tests++;
    if (obs !== {2'b10, ADD3, 32'h0, 32'h24, 32'h0}) begin
      fails++; $display("FAIL raw_second got=%h", obs);
    end
  endtask

  task automatic test_x0_exempt();
    drive(NOP, ADD30, 32'h40, 1'b0);
    tests++;
    if (StallF !== 1'b0) begin fails++; $display("FAIL x0_stall got=%b exp=0", StallF); end
    tick();
    tests++;
    if (obs !== {2'b11, NOP, ADD30, 32'h40, 32'h44}) begin
      fails++; $display("FAIL x0_issue got=%h", obs);
    end
  endtask

  task automatic test_mem_conflict();
    drive(LW1, LW3, 32'h50, 1'b0);
    tests++;
    if (StallF !== 1'b1) begin fails++; $display("FAIL mem_stall got=%b exp=1", StallF); end
    tick();
    tests++;
    if (obs !== {2'b10, LW1, 32'h0, 32'h50, 32'h0}) begin
      fails++; $display("FAIL mem_first got=%h", obs);
    end
    tick();
    tests++;
    if (obs !== {2'b10, LW3, 32'h0, 32'h54, 32'h0}) begin
      fails++; $display("FAIL mem_second got=%h", obs);
    end
  endtask

  task automatic test_ctrl_waw();
    drive(JAL0, ADDI2, 32'h60, 1'b0);
    tests++;
    if (StallF !== 1'b1) begin fails++; $display("FAIL ctrl_stall got=%b exp=1", StallF); end
    tick(); tick();
    drive(ADDI1, LUI1, 32'h70, 1'b0);
    tests++;
    if (StallF !== 1'b1) begin fails++; $display("FAIL waw_stall got=%b exp=1", StallF); end
    tick(); tick();
    tests++;
    if (obs !== {2'b10, LUI1, 32'h0, 32'h74, 32'h0}) begin
      fails++; $display("FAIL waw_second got=%h", obs);
    end
  endtask

  task automatic test_flush_split();
    drive(ADDI1, ADD3, 32'h20, 1'b0);
    tick();
    drive(ADDI1, ADD3, 32'h20, 1'b1);
    tests++;
    if (StallF !== 1'b0) begin fails++; $display("FAIL flush_split_stall got=%b exp=0", StallF); end
    tick();
    tests++;
    if (obs !== '0) begin fails++; $display("FAIL flush_split_out got=%h exp=0", obs); end
    drive(ADDI1, ADDI2, 32'h80, 1'b0);
    tick();
    tests++;
    if (obs !== {2'b11, ADDI1, ADDI2, 32'h80, 32'h84}) begin
      fails++; $display("FAIL flush_split_after got=%h", obs);
    end
  endtask

  task automatic test_flush_conflict();
    drive(ADDI1, ADD3, 32'h90, 1'b1);
    tests++;
    if (StallF !== 1'b0) begin fails++; $display("FAIL flush_conf_stall got=%b exp=0", StallF); end
    tick();
    tests++;
    if (obs !== '0) begin fails++; $display("FAIL flush_conf_out got=%h exp=0", obs); end
    drive(ADDI1, ADD3, 32'h90, 1'b0);
    tests++;
    if (StallF !== 1'b1) begin fails++; $display("FAIL flush_conf_nosplit got=%b exp=1", StallF); end
    tick(); tick();
  endtask

  task automatic test_boundaries();
    drive(ADDI1, ADDI2, 32'hFFFFFFFC, 1'b0);
    tick();
    tests++;
    if (obs !== {2'b11, ADDI1, ADDI2, 32'hFFFFFFFC, 32'h0}) begin
      fails++; $display("FAIL pc_wrap got=%h", obs);
    end
    drive(32'h0, ADDI2, 32'hA0, 1'b0);
    tick();
    tests++;
    if (obs !== {2'b01, 32'h0, ADDI2, 32'h0, 32'hA4}) begin
      fails++; $display("FAIL bubble_slot0 got=%h", obs);
    end
    drive(ADDI1, ADD3, 32'hB0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    tests++;
    if (obs !== '0) begin fails++; $display("FAIL reset_mid_split got=%h exp=0", obs); end
    rst = 1'b0;
    #1;
    tests++;
    if (StallF !== 1'b1) begin fails++; $display("FAIL reset_mid_split_state got=%b exp=1", StallF); end
  endtask

  initial begin
    rst = 1'b1; FlushD = 1'b0; InstrD1 = '0; InstrD2 = '0; PCD = '0;
    test_reset();
    test_independent();
    test_raw_split();
    test_x0_exempt();
    test_mem_conflict();
    test_ctrl_waw();
    test_flush_split();
    test_flush_conflict();
    test_boundaries();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
